// File: rtl/mul_share_arbiter_if.sv
// Requester-side bundle of mul_share_arbiter: two request ports, one-hot
// accept/response, shared result bus and stall indication.
interface mul_share_arbiter_if #(
    parameter int unsigned DW = 32
);
    logic [1:0]      req_valid;
    logic [3:0]      req_op;
    logic [2*DW-1:0] req_a;
    logic [2*DW-1:0] req_b;
    logic [1:0]      req_ready;
    logic [1:0]      resp_valid;
    logic [DW-1:0]   resp_data;
    logic            busy;

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin share of one iterative 32x32 unsigned multiplier between two requesters,
// with RISC-V MUL/MULH/MULHSU/MULHU sign handling. Optional MUL_REUSE_EN reuses last product.
module mul_share_arbiter #(
    parameter int unsigned DW      = 32,
    parameter bit          RR_INIT = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    mul_share_arbiter_if.slave req_if,
    output logic               mul_in_valid,
    output logic [DW-1:0]      mul_mplier,
    output logic [DW-1:0]      mul_mcand,
    input  logic [2*DW-1:0]    mul_product,
    input  logic               mul_out_valid
);
    localparam int unsigned PW = 2 * DW;
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e        state_q, state_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          gnt_q, gnt_d;
    logic [1:0]    op_q, op_d;
    logic          neg_q, neg_d;
    logic [DW-1:0] mplier_q, mplier_d;
    logic [DW-1:0] mcand_q, mcand_d;
    logic [DW-1:0] resp_data_q, resp_data_d;
    logic [1:0]    resp_valid_q, resp_valid_d;
    logic          mul_in_valid_q, mul_in_valid_d;
    logic          busy_q, busy_d;

    logic          any_req_c, gnt_c, sa_c, sb_c, hit_c;
    logic [1:0]    op_c;
    logic [DW-1:0] a_c, b_c, mag_a_c, mag_b_c;
    logic [1:0]    req_ready_c;
    logic [PW-1:0] hit_prod_c;

    // Sign-correct the unsigned product and pick the requested half.
    function automatic logic [DW-1:0] fix_result(input logic [PW-1:0] prod,
                                                 input logic          neg,
                                                 input logic [1:0]    op);
        logic [PW-1:0] fin;
        fin = neg ? (~prod) + PW'(1) : prod;
        return (op == OP_MUL) ? fin[DW-1:0] : fin[PW-1:DW];
    endfunction

    // Grant selection and operand magnitude conversion for the would-be winner.
    always_comb begin
        any_req_c = |req_if.req_valid;
        gnt_c     = req_if.req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
        op_c      = gnt_c ? req_if.req_op[3:2]    : req_if.req_op[1:0];
        a_c       = gnt_c ? req_if.req_a[PW-1:DW] : req_if.req_a[DW-1:0];
        b_c       = gnt_c ? req_if.req_b[PW-1:DW] : req_if.req_b[DW-1:0];
        sa_c      = ((op_c == OP_MULH) || (op_c == OP_MULHSU)) && a_c[DW-1];
        sb_c      = (op_c == OP_MULH) && b_c[DW-1];
        mag_a_c   = sa_c ? (~a_c) + DW'(1) : a_c;
        mag_b_c   = sb_c ? (~b_c) + DW'(1) : b_c;
    end

`ifdef MUL_REUSE_EN
    logic          cache_vld_q, cache_vld_d;
    logic [PW-1:0] cache_key_q, cache_key_d;
    logic [PW-1:0] cache_prod_q, cache_prod_d;

    // Key is the pair of post-conversion magnitudes actually sent to the multiplier.
    always_comb begin
        cache_vld_d  = cache_vld_q;
        cache_key_d  = cache_key_q;
        cache_prod_d = cache_prod_q;
        if ((state_q == S_WAIT) && mul_out_valid) begin
            cache_vld_d  = 1'b1;
            cache_key_d  = {mplier_q, mcand_q};
            cache_prod_d = mul_product;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld_q  <= 1'b0;
            cache_key_q  <= '0;
            cache_prod_q <= '0;
        end else begin
            cache_vld_q  <= cache_vld_d;
            cache_key_q  <= cache_key_d;
            cache_prod_q <= cache_prod_d;
        end
    end

    assign hit_c      = cache_vld_q && (cache_key_q == {mag_a_c, mag_b_c});
    assign hit_prod_c = cache_prod_q;
`else
    assign hit_c      = 1'b0;
    assign hit_prod_c = '0;
`endif

    // Next-state and output logic.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        gnt_d          = gnt_q;
        op_d           = op_q;
        neg_d          = neg_q;
        mplier_d       = mplier_q;
        mcand_d        = mcand_q;
        resp_data_d    = resp_data_q;
        resp_valid_d   = 2'b00;
        mul_in_valid_d = 1'b0;
        req_ready_c    = 2'b00;
        busy_d         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (any_req_c && !rst) begin
                    req_ready_c[gnt_c] = 1'b1;
                    gnt_d              = gnt_c;
                    op_d               = op_c;
                    neg_d              = sa_c ^ sb_c;
                    mplier_d           = mag_a_c;
                    mcand_d            = mag_b_c;
                    if (hit_c) begin
                        state_d             = S_RESP;
                        resp_valid_d[gnt_c] = 1'b1;
                        resp_data_d         = fix_result(hit_prod_c, sa_c ^ sb_c, op_c);
                    end else begin
                        state_d        = S_ISSUE;
                        mul_in_valid_d = 1'b1;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (mul_out_valid) begin
                    state_d             = S_RESP;
                    resp_valid_d[gnt_q] = 1'b1;
                    resp_data_d         = fix_result(mul_product, neg_q, op_q);
                end
            end
            S_RESP: begin
                rr_ptr_d = ~gnt_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= RR_INIT;
            gnt_q          <= 1'b0;
            op_q           <= OP_MUL;
            neg_q          <= 1'b0;
            mplier_q       <= '0;
            mcand_q        <= '0;
            resp_data_q    <= '0;
            resp_valid_q   <= 2'b00;
            mul_in_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            gnt_q          <= gnt_d;
            op_q           <= op_d;
            neg_q          <= neg_d;
            mplier_q       <= mplier_d;
            mcand_q        <= mcand_d;
            resp_data_q    <= resp_data_d;
            resp_valid_q   <= resp_valid_d;
            mul_in_valid_q <= mul_in_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign req_if.req_ready  = req_ready_c;
    assign req_if.resp_valid = resp_valid_q;
    assign req_if.resp_data  = resp_data_q;
    assign req_if.busy       = busy_q;
    assign mul_in_valid      = mul_in_valid_q;
    assign mul_mplier        = mplier_q;
    assign mul_mcand         = mcand_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with an 8-iteration multiplier model;
// latency of repeated operands depends on MUL_REUSE_EN.
module tb_mul_share_arbiter;
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;
`ifdef MUL_REUSE_EN
    localparam int REUSE_LAT = 1;
`else
    localparam int REUSE_LAT = 11;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mul_in_valid;
    logic [31:0] mul_mplier;
    logic [31:0] mul_mcand;
    logic [63:0] mul_product;
    logic        mul_out_valid;

    always #5 clk = ~clk;

    mul_share_arbiter_if bus ();

    mul_share_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req_if        (bus),
        .mul_in_valid  (mul_in_valid),
        .mul_mplier    (mul_mplier),
        .mul_mcand     (mul_mcand),
        .mul_product   (mul_product),
        .mul_out_valid (mul_out_valid)
    );

    // Multiplier model: done pulse 9 cycles after the start pulse, reset with the arbiter.
    int unsigned mcnt;
    logic        mpend;
    logic [63:0] mprod;
    always @(posedge clk) begin
        if (rst) begin
            mpend         <= 1'b0;
            mcnt          <= 0;
            mul_out_valid <= 1'b0;
            mul_product   <= '0;
        end else begin
            mul_out_valid <= 1'b0;
            if (mul_in_valid) begin
                mpend <= 1'b1;
                mcnt  <= 8;
                mprod <= 64'(mul_mplier) * 64'(mul_mcand);
            end else if (mpend) begin
                if (mcnt == 1) begin
                    mul_out_valid <= 1'b1;
                    mul_product   <= mprod;
                    mpend         <= 1'b0;
                end
                mcnt <= mcnt - 1;
            end
        end
    end

    int         cyc = 0;
    int         n_in = 0;
    int         n_resp = 0;
    int         in_cyc = 0;
    int         resp_cyc = 0;
    logic [1:0] resp_port = 2'b00;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mul_in_valid === 1'b1) begin
            n_in   <= n_in + 1;
            in_cyc <= cyc;
        end
        if (|bus.resp_valid) begin
            n_resp    <= n_resp + 1;
            resp_cyc  <= cyc;
            resp_port <= bus.resp_valid;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid[p]       = 1'b1;
        bus.req_op[2*p +: 2]   = op;
        bus.req_a[32*p +: 32]  = a;
        bus.req_b[32*p +: 32]  = b;
    endtask

    // Accept on port p this cycle, then follow the request to its response.
    task automatic serve(input int p, input logic [31:0] mpl, input logic [31:0] mcd,
                         input logic [31:0] data, input int lat);
        int t, nin0, nr0;
        #1;
        chk("req_ready", 64'(bus.req_ready), 64'(2'b01 << p));
        t    = cyc;
        nin0 = n_in;
        nr0  = n_resp;
        tick();
        bus.req_valid[p] = 1'b0;
        chk("mul_mplier", 64'(mul_mplier), 64'(mpl));
        chk("mul_mcand", 64'(mul_mcand), 64'(mcd));
        chk("busy_t1", 64'(bus.busy), 64'd1);
        chk("mul_in_valid_t1", 64'(mul_in_valid), (lat == 1) ? 64'd0 : 64'd1);
        for (int k = 0; k < 30 && n_resp == nr0; k++) tick();
        chk("resp_seen", 64'(n_resp - nr0), 64'd1);
        chk("resp_latency", 64'(resp_cyc - t), 64'(lat));
        chk("resp_port", 64'(resp_port), 64'(2'b01 << p));
        chk("resp_data", 64'(bus.resp_data), 64'(data));
        chk("mul_issues", 64'(n_in - nin0), (lat == 1) ? 64'd0 : 64'd1);
        if (lat != 1) chk("issue_cycle", 64'(in_cyc - t), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nin0, nr0;
        rst           = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        tick();
        bus.req_valid = 2'b01;
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        tick();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
        chk("rst_mplier", 64'(mul_mplier), 64'd0);
        chk("rst_mcand", 64'(mul_mcand), 64'd0);
        chk("rst_in_valid", 64'(mul_in_valid), 64'd0);
        bus.req_valid = 2'b00;
        rst           = 1'b0;
        tick();

        // Both valid with rr_ptr at reset value: port0 first, port1 right after RESP.
        drive(0, OP_MUL, 32'd5, 32'd6);
        drive(1, OP_MUL, 32'd7, 32'd8);
        serve(0, 32'd5, 32'd6, 32'h0000001E, 11);
        serve(1, 32'd7, 32'd8, 32'h00000038, 11);

        drive(0, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        serve(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 11);

        drive(1, OP_MUL, 32'hFFFFFFFD, 32'd7);
        serve(1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 11);
        drive(1, OP_MULH, 32'hFFFFFFFD, 32'd7);
        serve(1, 32'd3, 32'd7, 32'hFFFFFFFF, 11);

        drive(0, OP_MULHSU, 32'h80000000, 32'hFFFFFFFF);
        serve(0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 11);

        // Last served was port0, so port1 wins this time.
        drive(0, OP_MUL, 32'd9, 32'd9);
        drive(1, OP_MUL, 32'd3, 32'd4);
        serve(1, 32'd3, 32'd4, 32'h0000000C, 11);
        serve(0, 32'd9, 32'd9, 32'h00000051, 11);

        // Reset while waiting on the multiplier drops the request.
        drive(0, OP_MULHU, 32'd5, 32'd7);
        #1;
        chk("rstw_req_ready", 64'(bus.req_ready), 64'd1);
        nin0 = n_in;
        nr0  = n_resp;
        tick();
        bus.req_valid = 2'b00;
        repeat (3) tick();
        chk("rstw_busy_before", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_busy_after", 64'(bus.busy), 64'd0);
        chk("rstw_resp_data", 64'(bus.resp_data), 64'd0);
        chk("rstw_mplier", 64'(mul_mplier), 64'd0);
        repeat (12) tick();
        chk("rstw_no_resp", 64'(n_resp - nr0), 64'd0);
        chk("rstw_issues", 64'(n_in - nin0), 64'd1);
        chk("rstw_busy_idle", 64'(bus.busy), 64'd0);
        drive(0, OP_MULHU, 32'd2, 32'd3);
        serve(0, 32'd2, 32'd3, 32'h00000000, 11);

        // Repeated magnitudes: cached result when reuse is built in.
        drive(0, OP_MULH, 32'h12345678, 32'h00000010);
        serve(0, 32'h12345678, 32'h00000010, 32'h00000001, 11);
        drive(0, OP_MUL, 32'h12345678, 32'h00000010);
        serve(0, 32'h12345678, 32'h00000010, 32'h23456780, REUSE_LAT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
